lcd_pattern_gen: RTL and testbench

- Test-pattern stage fed by the LCD timing generator's `active_x`/`active_y`/`hs`/`vs`/`de`.
- Drives the RGB565 panel pins with selectable patterns: colour bars, grid, gradient, checkerboard, bouncing box, solid white.
- Re-times sync/DE to match pixel latency.
- Switches pattern only at frame boundaries, manually or by auto-cycling on a frame count.

---
 rtl/lcd_pattern_gen.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_gen.sv
// Test-pattern stage for an RGB565 LCD panel. Takes raster position and sync
// from the timing generator and produces pixel colour with a fixed 2-clock
// latency. Pattern and bouncing-box state change only at frame start.
module lcd_pattern_gen #(
  parameter int unsigned H_ACTIVE           = 480,
  parameter int unsigned V_ACTIVE           = 272,
  parameter int unsigned FRAMES_PER_PATTERN = 120,
  parameter bit          VS_ACTIVE_LEVEL    = 1'b0,
  parameter int unsigned BOX_SIZE           = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] pat_sel_i,
  input  logic       auto_cycle_i,
  input  logic       in_hs_i,
  input  logic       in_vs_i,
  input  logic       in_de_i,
  input  logic [9:0] in_x_i,
  input  logic [9:0] in_y_i,
  output logic       out_hs_o,
  output logic       out_vs_o,
  output logic       out_de_o,
  output logic [4:0] out_r_o,
  output logic [5:0] out_g_o,
  output logic [4:0] out_b_o,
  output logic [2:0] pat_cur_o
);

  localparam logic [9:0]  XLast     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  YLast     = 10'(V_ACTIVE - 1);
  localparam int unsigned BarW      = H_ACTIVE / 8;
  localparam logic [9:0]  BoxXLim   = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  BoxYLim   = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] BoxSz     = 11'(BOX_SIZE);
  localparam logic [31:0] FrameLast = 32'(FRAMES_PER_PATTERN - 1);

  // Frame-rate state
  logic        vs_hist_q;
  logic        fs;
  logic [2:0]  pat_q, pat_d;
  logic [31:0] cnt_q, cnt_d;
  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = moving +

  // Pipeline state
  logic       s1_hs_q, s1_vs_q, s1_de_q;
  logic [9:0] x_q, y_q;
  logic       hs_q, vs_q, de_q;
  logic [4:0] r_q, b_q, pix_r, pix_b;
  logic [5:0] g_q, pix_g;
  logic [2:0] bar;
  logic       box_hit;

  // Frame start: first cycle of the vertical sync pulse.
  assign fs = (in_vs_i == VS_ACTIVE_LEVEL) && (vs_hist_q != VS_ACTIVE_LEVEL);

  // Next pattern, frame counter and box position; all held except on fs.
  always_comb begin
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (fs) begin
      if (!auto_cycle_i) begin
        pat_d = pat_sel_i;
        cnt_d = '0;
      end else if (cnt_q >= FrameLast) begin
        cnt_d = '0;
        pat_d = (pat_q >= 3'd5) ? 3'd0 : pat_q + 3'd1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end

      if (dir_x_q) begin
        if (11'(box_x_q) + 11'd2 >= 11'(BoxXLim)) begin
          box_x_d = BoxXLim;
          dir_x_d = 1'b0;
        end else begin
          box_x_d = box_x_q + 10'd2;
        end
      end else if (box_x_q < 10'd2) begin
        box_x_d = '0;
        dir_x_d = 1'b1;
      end else begin
        box_x_d = box_x_q - 10'd2;
      end

      if (dir_y_q) begin
        if (11'(box_y_q) + 11'd1 >= 11'(BoxYLim)) begin
          box_y_d = BoxYLim;
          dir_y_d = 1'b0;
        end else begin
          box_y_d = box_y_q + 10'd1;
        end
      end else if (box_y_q < 10'd1) begin
        box_y_d = '0;
        dir_y_d = 1'b1;
      end else begin
        box_y_d = box_y_q - 10'd1;
      end
    end
  end

  // Frame-rate state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_hist_q <= ~VS_ACTIVE_LEVEL;
      pat_q     <= '0;
      cnt_q     <= '0;
      box_x_q   <= '0;
      box_y_q   <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
    end else begin
      vs_hist_q <= in_vs_i;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
    end
  end

  // Pixel colour from the stage-1 position and current pattern.
  always_comb begin
    bar = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(x_q) >= k * BarW) bar = bar + 3'd1;
    end
    box_hit = (11'(x_q) >= 11'(box_x_q)) && (11'(x_q) < 11'(box_x_q) + BoxSz) &&
              (11'(y_q) >= 11'(box_y_q)) && (11'(y_q) < 11'(box_y_q) + BoxSz);
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (pat_q)
      3'd0: begin
        // Bar order white..black maps to inverted index bits per channel.
        pix_r = {5{~bar[1]}};
        pix_g = {6{~bar[2]}};
        pix_b = {5{~bar[0]}};
      end
      3'd1: begin
        if (x_q[4:0] == 5'd0 || y_q[4:0] == 5'd0 || x_q == XLast || y_q == YLast) begin
          pix_r = '1;
          pix_g = '1;
          pix_b = '1;
        end
      end
      3'd2: begin
        pix_r = x_q[8:4];
        pix_g = x_q[8:3];
        pix_b = x_q[8:4];
      end
      3'd3: begin
        if (x_q[5] ^ y_q[5]) begin
          pix_r = '1;
          pix_g = '1;
          pix_b = '1;
        end
      end
      3'd4: begin
        if (box_hit) pix_r = '1;
        else         pix_b = 5'd8;
      end
      3'd5: begin
        pix_r = '1;
        pix_g = '1;
        pix_b = '1;
      end
      default: ;
    endcase
  end

  // Two-stage pipeline; position is held while DE is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_hs_q <= 1'b0;
      s1_vs_q <= 1'b0;
      s1_de_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      s1_hs_q <= in_hs_i;
      s1_vs_q <= in_vs_i;
      s1_de_q <= in_de_i;
      if (in_de_i) begin
        x_q <= in_x_i;
        y_q <= in_y_i;
      end
      hs_q <= s1_hs_q;
      vs_q <= s1_vs_q;
      de_q <= s1_de_q;
      r_q  <= s1_de_q ? pix_r : 5'd0;
      g_q  <= s1_de_q ? pix_g : 6'd0;
      b_q  <= s1_de_q ? pix_b : 5'd0;
    end
  end

  assign out_hs_o  = hs_q;
  assign out_vs_o  = vs_q;
  assign out_de_o  = de_q;
  assign out_r_o   = r_q;
  assign out_g_o   = g_q;
  assign out_b_o   = b_q;
  assign pat_cur_o = pat_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: random raster stimulus against a behavioural
// model, plus directed pixel checks with fixed expected colours.
module tb_lcd_pattern_gen;

  localparam int H   = 480;
  localparam int V   = 272;
  localparam int F   = 2;
  localparam int BOX = 32;

  localparam logic [15:0] White = 16'hFFFF;
  localparam logic [15:0] Black = 16'h0000;
  localparam logic [15:0] Red   = 16'hF800;
  localparam logic [15:0] DkBlu = 16'h0008;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pat_sel = 3'd0;
  logic       auto_cycle = 1'b0;
  logic       in_hs = 1'b0, in_vs = 1'b1, in_de = 1'b0;
  logic [9:0] in_x = '0, in_y = '0;
  logic       out_hs, out_vs, out_de;
  logic [4:0] out_r, out_b;
  logic [5:0] out_g;
  logic [2:0] pat_cur;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int         m_pat, m_cnt, m_bx, m_by;
  bit         m_dx, m_dy, m_vs_prev;
  logic [18:0] e_mid, e_out;  // {hs, vs, de, rgb565}

  always #5 clk = ~clk;

  lcd_pattern_gen #(
    .H_ACTIVE          (H),
    .V_ACTIVE          (V),
    .FRAMES_PER_PATTERN(F),
    .VS_ACTIVE_LEVEL   (1'b0),
    .BOX_SIZE          (BOX)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pat_sel_i   (pat_sel),
    .auto_cycle_i(auto_cycle),
    .in_hs_i     (in_hs),
    .in_vs_i     (in_vs),
    .in_de_i     (in_de),
    .in_x_i      (in_x),
    .in_y_i      (in_y),
    .out_hs_o    (out_hs),
    .out_vs_o    (out_vs),
    .out_de_o    (out_de),
    .out_r_o     (out_r),
    .out_g_o     (out_g),
    .out_b_o     (out_b),
    .pat_cur_o   (pat_cur)
  );

  function automatic logic [15:0] rgb(int r, int g, int b);
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  function automatic logic [15:0] colour(int pat, int x, int y, int bx, int by);
    int bar;
    case (pat)
      0: begin
        bar = x / (H / 8);
        if (bar > 7) bar = 7;
        case (bar)
          0: return rgb(31, 63, 31);
          1: return rgb(31, 63, 0);
          2: return rgb(0, 63, 31);
          3: return rgb(0, 63, 0);
          4: return rgb(31, 0, 31);
          5: return rgb(31, 0, 0);
          6: return rgb(0, 0, 31);
          default: return rgb(0, 0, 0);
        endcase
      end
      1: return (x % 32 == 0 || y % 32 == 0 || x == H - 1 || y == V - 1) ? White : Black;
      2: return rgb((x / 16) % 32, (x / 8) % 64, (x / 16) % 32);
      3: return (((x / 32) % 2) != ((y / 32) % 2)) ? White : Black;
      4: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? Red : DkBlu;
      5: return White;
      default: return Black;
    endcase
  endfunction

  task automatic new_frame();
    if (!auto_cycle) begin
      m_pat = int'(pat_sel);
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == F) begin
        m_cnt = 0;
        m_pat = (m_pat < 5) ? m_pat + 1 : 0;
      end
    end
    if (m_dx) begin
      if (m_bx + 2 >= H - BOX) begin m_bx = H - BOX; m_dx = 0; end
      else m_bx += 2;
    end else begin
      if (m_bx < 2) begin m_bx = 0; m_dx = 1; end
      else m_bx -= 2;
    end
    if (m_dy) begin
      if (m_by + 1 >= V - BOX) begin m_by = V - BOX; m_dy = 0; end
      else m_by += 1;
    end else begin
      if (m_by < 1) begin m_by = 0; m_dy = 1; end
      else m_by -= 1;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pat = 0; m_cnt = 0; m_bx = 0; m_by = 0;
      m_dx = 1; m_dy = 1; m_vs_prev = 1;
      e_out = '0; e_mid = '0;
    end else begin
      if (in_vs == 1'b0 && m_vs_prev == 1'b1) new_frame();
      m_vs_prev = in_vs;
      e_out = e_mid;
      e_mid = {in_hs, in_vs, in_de,
               in_de ? colour(m_pat, int'(in_x), int'(in_y), m_bx, m_by) : 16'h0};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive on negedge, model on posedge, compare just after.
  task automatic cycle(input logic hs, input logic vs, input logic de, input int x, input int y);
    @(negedge clk);
    in_hs = hs; in_vs = vs; in_de = de; in_x = 10'(x); in_y = 10'(y);
    @(posedge clk);
    model_edge();
    #1;
    chk("pipe", {13'd0, out_hs, out_vs, out_de, out_r, out_g, out_b}, {13'd0, e_out});
    chk("pat_cur", {29'd0, pat_cur}, 32'(m_pat));
  endtask

  task automatic pix_const(input int x, input int y, input logic [15:0] exp, input string tag);
    cycle(1'b0, 1'b1, 1'b1, x, y);
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
    chk(tag, {16'd0, out_r, out_g, out_b}, {16'd0, exp});
  endtask

  task automatic vs_pulse();
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic rand_pixels(input int n, input bit near_box);
    int x, y;
    for (int i = 0; i < n; i++) begin
      if (near_box) begin
        x = clampi(m_bx - 2 + int'($urandom_range(0, BOX + 3)), 0, H - 1);
        y = clampi(m_by - 2 + int'($urandom_range(0, BOX + 3)), 0, V - 1);
      end else begin
        x = int'($urandom_range(0, H - 1));
        y = int'($urandom_range(0, V - 1));
      end
      cycle($urandom_range(0, 15) == 0, 1'b1, $urandom_range(0, 9) != 0, x, y);
    end
  endtask

  task automatic frame(input int n, input bit near_box);
    vs_pulse();
    rand_pixels(n, near_box);
  endtask

  int  seq[12] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};
  bit  seen_x, seen_y;

  initial begin
    // Reset
    rst = 1'b1;
    rand_pixels(3, 1'b0);
    chk("rst_pat", {29'd0, pat_cur}, 32'd0);
    chk("rst_out", {13'd0, out_hs, out_vs, out_de, out_r, out_g, out_b}, 32'd0);
    rst = 1'b0;

    // Colour bars
    auto_cycle = 1'b0;
    pat_sel = 3'd0;
    frame(40, 1'b0);
    pix_const(0, 10, White, "bar_x0");
    pix_const(59, 10, White, "bar_x59");
    pix_const(60, 10, rgb(31, 63, 0), "bar_x60");
    pix_const(240, 10, rgb(31, 0, 31), "bar_x240");
    pix_const(419, 10, rgb(0, 0, 31), "bar_x419");
    pix_const(479, 10, Black, "bar_x479");

    // Mid-frame select change takes effect only at next frame start
    pat_sel = 3'd3;
    rand_pixels(30, 1'b0);
    pix_const(60, 100, rgb(31, 63, 0), "bar_hold");
    chk("pat_hold", {29'd0, pat_cur}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    chk("pat_on_fs", {29'd0, pat_cur}, 32'd3);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
    pix_const(32, 0, White, "chk_32_0");
    pix_const(32, 32, Black, "chk_32_32");

    // Random manual patterns with random mid-frame selects
    for (int f = 0; f < 10; f++) begin
      pat_sel = 3'($urandom_range(0, 7));
      frame(50, 1'b0);
      pat_sel = 3'($urandom_range(0, 7));
      rand_pixels(20, 1'b0);
    end

    // Auto-cycle sequence from reset
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
    rst = 1'b0;
    auto_cycle = 1'b1;
    pat_sel = 3'($urandom_range(0, 7));
    chk("auto_f0", {29'd0, pat_cur}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      vs_pulse();
      chk($sformatf("auto_f%0d", i + 1), {29'd0, pat_cur}, 32'(seq[i]));
      rand_pixels(10, 1'b0);
    end

    // Pattern 6 rolls over to 0 in auto mode
    auto_cycle = 1'b0;
    pat_sel = 3'd6;
    vs_pulse();
    chk("p6_manual", {29'd0, pat_cur}, 32'd6);
    auto_cycle = 1'b1;
    rand_pixels(10, 1'b0);
    vs_pulse();
    chk("p6_hold", {29'd0, pat_cur}, 32'd6);
    vs_pulse();
    chk("p6_wrap", {29'd0, pat_cur}, 32'd0);

    // Bouncing box across both limits
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
    rst = 1'b0;
    auto_cycle = 1'b0;
    pat_sel = 3'd4;
    seen_x = 1'b0;
    seen_y = 1'b0;
    for (int f = 0; f < 260; f++) begin
      frame(16, 1'b1);
      if (m_bx == H - BOX && !seen_x) begin
        seen_x = 1'b1;
        pix_const(H - BOX, m_by, Red, "box_xmax_in");
        pix_const(H - BOX - 1, m_by, DkBlu, "box_xmax_out");
        pix_const(H - 1, m_by, Red, "box_xmax_edge");
      end
      if (m_by == V - BOX && !seen_y) begin
        seen_y = 1'b1;
        pix_const(m_bx, V - BOX, Red, "box_ymax_in");
        pix_const(m_bx, V - BOX - 1, DkBlu, "box_ymax_out");
      end
    end
    chk("box_x_turned", {31'd0, seen_x}, 32'd1);
    chk("box_y_turned", {31'd0, seen_y}, 32'd1);

    // Blanking with solid white: RGB zero, sync pulses delayed intact
    pat_sel = 3'd5;
    vs_pulse();
    for (int i = 0; i < 12; i++) begin
      cycle(i < 3, 1'b1, 1'b0, int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)));
    end
    pix_const(100, 100, White, "white_active");
    for (int i = 0; i < 4; i++) cycle(1'b0, i < 2 ? 1'b0 : 1'b1, 1'b0, 5, 5);

    // Reset asserted for one cycle mid-line
    pat_sel = 3'd4;
    frame(20, 1'b1);
    rand_pixels(5, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 50, 50);
    chk("rst_mid", {10'd0, out_hs, out_vs, out_de, out_r, out_g, out_b, pat_cur}, 32'd0);
    rst = 1'b0;
    pix_const(2, 1, White, "rst_pat0");
    vs_pulse();
    pix_const(2, 1, Red, "box_home_in");
    pix_const(33, 32, Red, "box_home_far");
    pix_const(1, 1, DkBlu, "box_home_left");
    pix_const(34, 1, DkBlu, "box_home_right");
    pix_const(2, 0, DkBlu, "box_home_top");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
